// File: rtl/gcd_param_if.sv
// Command/result bundle for the gcd_param coprocessor.
// The master drives operands and controls; the slave returns result and status.
interface gcd_param_if #(
    parameter int W = 8
);
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         START;
    logic         ABORT;
    logic [W-1:0] Y;
    logic         DONE;
    logic         ERROR;
    logic         BUSY;
    logic [W-1:0] ITER;
    logic         COPRIME;

    modport master (
        output A, B, START, ABORT,
        input  Y, DONE, ERROR, BUSY, ITER, COPRIME
    );

    modport slave (
        input  A, B, START, ABORT,
        output Y, DONE, ERROR, BUSY, ITER, COPRIME
    );
endinterface

// File: rtl/gcd_param.sv
// Subtractive Euclid GCD engine with START/DONE handshake, abort, iteration
// count, coprime flag and a selectable policy for zero operands.
module gcd_param #(
    parameter int W         = 8,
    parameter int ZERO_MODE = 0
) (
    input  logic          CLK,
    input  logic          RST,
    gcd_param_if.slave    bus
);
    localparam logic [1:0]   S_IDLE    = 2'd0;
    localparam logic [1:0]   S_CALC    = 2'd1;
    localparam logic [1:0]   S_FINISH  = 2'd2;
    localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};
    localparam bit           ZERO_PASS = (ZERO_MODE != 0);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] ra_q, ra_d;
    logic [W-1:0] rb_q, rb_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] iter_q, iter_d;
    logic         error_q, error_d;
    logic         coprime_q, coprime_d;
    logic         a_zero, b_zero;
    logic [W-1:0] nonzero_op;

    assign a_zero     = (bus.A == '0);
    assign b_zero     = (bus.B == '0);
    assign nonzero_op = a_zero ? bus.B : bus.A;

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        y_d       = y_q;
        iter_d    = iter_q;
        error_d   = error_q;
        coprime_d = coprime_q;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    ra_d      = bus.A;
                    rb_d      = bus.B;
                    y_d       = '0;
                    iter_d    = '0;
                    coprime_d = 1'b0;
                    error_d   = 1'b0;
                    if ((a_zero && b_zero) || (!ZERO_PASS && (a_zero || b_zero))) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else if (a_zero || b_zero) begin
                        // Exactly one zero operand: the other one is the answer.
                        y_d       = nonzero_op;
                        coprime_d = (nonzero_op == ONE);
                        state_d   = S_FINISH;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else if (ra_q == rb_q) begin
                    y_d       = ra_q;
                    coprime_d = (ra_q == ONE);
                    state_d   = S_FINISH;
                end else begin
                    if (ra_q > rb_q) begin
                        ra_d = ra_q - rb_q;
                    end else begin
                        rb_d = rb_q - ra_q;
                    end
                    iter_d = iter_q + ONE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            y_q       <= '0;
            iter_q    <= '0;
            error_q   <= 1'b0;
            coprime_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            y_q       <= y_d;
            iter_q    <= iter_d;
            error_q   <= error_d;
            coprime_q <= coprime_d;
        end
    end

    assign bus.Y       = y_q;
    assign bus.ITER    = iter_q;
    assign bus.ERROR   = error_q;
    assign bus.COPRIME = coprime_q;
    assign bus.DONE    = (state_q == S_FINISH);
    assign bus.BUSY    = (state_q == S_CALC);
endmodule

// File: tb/tb_gcd_param.sv
// Bench for gcd_param: vector table, randomized jobs against a modulo-Euclid
// reference model, and hand sequences for abort, ignored START and reset.
module tb_gcd_param;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic [7:0] iter;
        logic       err;
        logic       cop;
        int         edges;
    } vec_t;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    vec_t vecs[$];

    gcd_param_if #(.W(8))  bus8();
    gcd_param_if #(.W(8))  busZ();
    gcd_param_if #(.W(16)) busW();

    gcd_param #(.W(8),  .ZERO_MODE(0)) u_dut  (.CLK(CLK), .RST(RST), .bus(bus8));
    gcd_param #(.W(8),  .ZERO_MODE(1)) u_zm   (.CLK(CLK), .RST(RST), .bus(busZ));
    gcd_param #(.W(16), .ZERO_MODE(0)) u_w16  (.CLK(CLK), .RST(RST), .bus(busW));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // GCD by division-based Euclid; the subtractive engine takes one fewer
    // subtraction than the sum of quotients, since it stops at ra==rb.
    function automatic void refModel(input int a, input int b, input int zm,
                                     output int y, output int it, output int err,
                                     output int cop, output int edges);
        int x, z, t, qsum;
        y = 0; it = 0; err = 0; cop = 0; edges = 0;
        if ((a == 0 && b == 0) || (zm == 0 && (a == 0 || b == 0))) begin
            err = 1;
            return;
        end
        if (a == 0 || b == 0) begin
            y   = a + b;
            cop = (y == 1) ? 1 : 0;
            return;
        end
        x = a; z = b; qsum = 0;
        while (z != 0) begin
            qsum += x / z;
            t = x % z;
            x = z;
            z = t;
        end
        y     = x;
        it    = qsum - 1;
        cop   = (y == 1) ? 1 : 0;
        edges = it + 1;
    endfunction

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        bus8.A     = a;
        bus8.B     = b;
        bus8.START = 1'b1;
        @(posedge CLK); #1;
        bus8.START = 1'b0;
    endtask

    task automatic waitDone(output int edges, output int busy);
        edges = 0;
        busy  = 0;
        while (!bus8.DONE && edges < 700) begin
            if (bus8.BUSY) busy++;
            @(posedge CLK); #1;
            edges++;
        end
    endtask

    task automatic runVec(input string tag, input vec_t v);
        int e, bz;
        applyStimulus(v.a, v.b);
        waitDone(e, bz);
        checkOutput({tag, ".done"},    bus8.DONE, 1);
        checkOutput({tag, ".latency"}, e, v.edges);
        checkOutput({tag, ".busy"},    bz, v.edges);
        checkOutput({tag, ".y"},       bus8.Y, v.y);
        checkOutput({tag, ".iter"},    bus8.ITER, v.iter);
        checkOutput({tag, ".error"},   bus8.ERROR, v.err);
        checkOutput({tag, ".coprime"}, bus8.COPRIME, v.cop);
        @(posedge CLK); #1;
        checkOutput({tag, ".pulse"},   bus8.DONE, 0);
    endtask

    task automatic runZm(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ey, input logic ee, input logic ec);
        busZ.A     = a;
        busZ.B     = b;
        busZ.START = 1'b1;
        @(posedge CLK); #1;
        busZ.START = 1'b0;
        checkOutput({tag, ".done"},    busZ.DONE, 1);
        checkOutput({tag, ".y"},       busZ.Y, ey);
        checkOutput({tag, ".error"},   busZ.ERROR, ee);
        checkOutput({tag, ".coprime"}, busZ.COPRIME, ec);
        checkOutput({tag, ".iter"},    busZ.ITER, 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        int ry, rit, rerr, rcop, redges;
        int e, bz;
        bit sawDone;
        vec_t v;

        checks = 0;
        errors = 0;
        RST = 1'b1;
        bus8.A = '0; bus8.B = '0; bus8.START = 1'b0; bus8.ABORT = 1'b0;
        busZ.A = '0; busZ.B = '0; busZ.START = 1'b0; busZ.ABORT = 1'b0;
        busW.A = '0; busW.B = '0; busW.START = 1'b0; busW.ABORT = 1'b0;

        vecs.push_back('{8'd12,  8'd8,   8'd4,  8'd2,   1'b0, 1'b0, 3});
        vecs.push_back('{8'd8,   8'd12,  8'd4,  8'd2,   1'b0, 1'b0, 3});
        vecs.push_back('{8'd12,  8'd12,  8'd12, 8'd0,   1'b0, 1'b0, 1});
        vecs.push_back('{8'd17,  8'd5,   8'd1,  8'd6,   1'b0, 1'b1, 7});
        vecs.push_back('{8'd0,   8'd9,   8'd0,  8'd0,   1'b1, 1'b0, 0});
        vecs.push_back('{8'd9,   8'd0,   8'd0,  8'd0,   1'b1, 1'b0, 0});
        vecs.push_back('{8'd1,   8'd1,   8'd1,  8'd0,   1'b0, 1'b1, 1});
        vecs.push_back('{8'd255, 8'd1,   8'd1,  8'd254, 1'b0, 1'b1, 255});
        vecs.push_back('{8'd1,   8'd255, 8'd1,  8'd254, 1'b0, 1'b1, 255});

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset.y",       bus8.Y, 0);
        checkOutput("reset.iter",    bus8.ITER, 0);
        checkOutput("reset.done",    bus8.DONE, 0);
        checkOutput("reset.busy",    bus8.BUSY, 0);
        checkOutput("reset.error",   bus8.ERROR, 0);
        checkOutput("reset.coprime", bus8.COPRIME, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        foreach (vecs[i]) runVec($sformatf("vec%0d", i), vecs[i]);

        for (int n = 0; n < 30; n++) begin
            v.a = 8'($urandom_range(0, 255));
            v.b = 8'($urandom_range(0, 255));
            if (n % 10 == 3) v.b = 8'd0;
            refModel(int'(v.a), int'(v.b), 0, ry, rit, rerr, rcop, redges);
            v.y = 8'(ry); v.iter = 8'(rit); v.err = rerr[0]; v.cop = rcop[0]; v.edges = redges;
            runVec($sformatf("rnd%0d", n), v);
        end

        runZm("zm0_9",  8'd0, 8'd9, 8'd9, 1'b0, 1'b0);
        runZm("zm9_0",  8'd9, 8'd0, 8'd9, 1'b0, 1'b0);
        runZm("zm0_1",  8'd0, 8'd1, 8'd1, 1'b0, 1'b1);
        runZm("zm0_0",  8'd0, 8'd0, 8'd0, 1'b1, 1'b0);

        busW.A = 16'd48000; busW.B = 16'd36000; busW.START = 1'b1;
        @(posedge CLK); #1;
        busW.START = 1'b0;
        e = 0;
        while (!busW.DONE && e < 50) begin
            @(posedge CLK); #1;
            e++;
        end
        checkOutput("w16.done",    busW.DONE, 1);
        checkOutput("w16.latency", e, 4);
        checkOutput("w16.y",       busW.Y, 12000);
        checkOutput("w16.iter",    busW.ITER, 3);
        @(posedge CLK); #1;

        // Abort on the 10th CALC cycle, with START raised at the same time.
        applyStimulus(8'd255, 8'd1);
        repeat (9) begin @(posedge CLK); #1; end
        bus8.ABORT = 1'b1; bus8.START = 1'b1; bus8.A = 8'd3; bus8.B = 8'd3;
        @(posedge CLK); #1;
        bus8.ABORT = 1'b0; bus8.START = 1'b0;
        checkOutput("abort.busy",  bus8.BUSY, 0);
        checkOutput("abort.iter",  bus8.ITER, 9);
        checkOutput("abort.y",     bus8.Y, 0);
        checkOutput("abort.error", bus8.ERROR, 0);
        sawDone = 1'b0;
        repeat (4) begin
            if (bus8.DONE || bus8.BUSY) sawDone = 1'b1;
            @(posedge CLK); #1;
        end
        checkOutput("abort.quiet", sawDone, 0);

        applyStimulus(8'd12, 8'd8);
        bus8.START = 1'b1; bus8.A = 8'd3; bus8.B = 8'd3;
        @(posedge CLK); #1;
        bus8.START = 1'b0;
        waitDone(e, bz);
        checkOutput("startcalc.y",    bus8.Y, 4);
        checkOutput("startcalc.iter", bus8.ITER, 2);
        bus8.START = 1'b1;
        @(posedge CLK); #1;
        bus8.START = 1'b0;
        @(posedge CLK); #1;
        checkOutput("startfin.busy", bus8.BUSY, 0);
        checkOutput("startfin.done", bus8.DONE, 0);
        checkOutput("startfin.y",    bus8.Y, 4);

        bus8.A = 8'd17; bus8.B = 8'd5; bus8.START = 1'b1;
        waitDone(e, bz);
        @(posedge CLK); #1;
        checkOutput("b2b.idle", bus8.BUSY, 0);
        @(posedge CLK); #1;
        checkOutput("b2b.again", bus8.BUSY, 1);
        bus8.START = 1'b0;
        waitDone(e, bz);
        checkOutput("b2b.y", bus8.Y, 1);
        @(posedge CLK); #1;

        applyStimulus(8'd255, 8'd1);
        repeat (5) begin @(posedge CLK); #1; end
        #2 RST = 1'b1;
        #1;
        checkOutput("rstcalc.busy", bus8.BUSY, 0);
        checkOutput("rstcalc.iter", bus8.ITER, 0);
        checkOutput("rstcalc.done", bus8.DONE, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        applyStimulus(8'd12, 8'd8);
        waitDone(e, bz);
        RST = 1'b1;
        #1;
        checkOutput("rstfin.done",    bus8.DONE, 0);
        checkOutput("rstfin.y",       bus8.Y, 0);
        checkOutput("rstfin.iter",    bus8.ITER, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        runVec("postrst", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
